// File: rtl/spi_xfer_arbiter_if.sv
// rtl/spi_xfer_arbiter_if.sv - requester, RAM and SPI engine signal bundle for spi_xfer_arbiter
interface spi_xfer_arbiter_if #(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 24
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ*ADDR_WIDTH-1:0] req_addr;
  logic [NREQ-1:0]            req_wb;
  logic [NREQ-1:0]            req_grant;
  logic [NREQ-1:0]            rsp_valid;
  logic                       rsp_crc_ok;
  logic                       rsp_err;
  logic                       ram_cs;
  logic                       ram_we;
  logic [ADDR_WIDTH-1:0]      ram_addr;
  logic [DATA_WIDTH-1:0]      ram_wdata;
  logic [DATA_WIDTH-1:0]      ram_rdata;
  logic                       spi_start;
  logic [DATA_WIDTH-1:0]      spi_tx_data;
  logic                       spi_busy;
  logic                       spi_done;
  logic [DATA_WIDTH-1:0]      spi_rx_data;
  logic                       spi_crc_ok;
  logic                       busy;

  modport slave (
    input  req_valid, req_addr, req_wb, ram_rdata, spi_busy, spi_done, spi_rx_data, spi_crc_ok,
    output req_grant, rsp_valid, rsp_crc_ok, rsp_err, ram_cs, ram_we, ram_addr, ram_wdata,
           spi_start, spi_tx_data, busy
  );

  modport master (
    output req_valid, req_addr, req_wb, ram_rdata, spi_busy, spi_done, spi_rx_data, spi_crc_ok,
    input  req_grant, rsp_valid, rsp_crc_ok, rsp_err, ram_cs, ram_we, ram_addr, ram_wdata,
           spi_start, spi_tx_data, busy
  );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// rtl/spi_xfer_arbiter.sv - round-robin SPI/RAM transaction scheduler; SPI_ARB_TIMEOUT_EN adds an XFER watchdog
module spi_xfer_arbiter #(
  parameter int NREQ        = 4,
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 24,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic               clk,
  input logic               rst,
  spi_xfer_arbiter_if.slave bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RDW, S_LAUNCH, S_XFER, S_WB, S_RESP} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      rr_ptr, rr_ptr_nxt, win, win_nxt, sel;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic                  wb_q, wb_nxt, crc_q, crc_nxt;
  logic                  found, timeout;
  int                    idx;

  logic [NREQ-1:0]       grant_q, grant_d, rspv_q, rspv_d;
  logic                  rsp_crc_q, rsp_crc_d, rsp_err_q, rsp_err_d;
  logic                  ram_cs_q, ram_cs_d, ram_we_q, ram_we_d;
  logic                  start_q, start_d, busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d, tx_q, tx_d;

  // First pending requester at or after rr_ptr, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != S_XFER) to_cnt <= '0;
    else                        to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // Outputs are computed for the next state and registered below.
  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    win_nxt     = win;
    addr_nxt    = addr_q;
    wb_nxt      = wb_q;
    crc_nxt     = crc_q;
    grant_d     = '0;
    rspv_d      = '0;
    rsp_crc_d   = 1'b0;
    rsp_err_d   = 1'b0;
    ram_cs_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    start_d     = 1'b0;
    tx_d        = tx_q;
    case (state)
      S_IDLE: begin
        if (found && !bus.spi_busy) begin
          win_nxt      = sel;
          addr_nxt     = bus.req_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
          wb_nxt       = bus.req_wb[sel];
          grant_d[sel] = 1'b1;
          ram_cs_d     = 1'b1;
          ram_addr_d   = addr_nxt;
          state_nxt    = S_RD;
        end
      end
      S_RD: state_nxt = S_RDW;
      S_RDW: begin
        tx_d      = bus.ram_rdata;
        start_d   = 1'b1;
        state_nxt = S_LAUNCH;
      end
      S_LAUNCH: state_nxt = S_XFER;
      S_XFER: begin
        if (bus.spi_done) begin
          crc_nxt = bus.spi_crc_ok;
          if (wb_q && bus.spi_crc_ok) begin
            ram_cs_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = addr_q;
            ram_wdata_d = bus.spi_rx_data;
          end
          state_nxt = S_WB;
        end else if (timeout) begin
          rspv_d[win] = 1'b1;
          rsp_err_d   = 1'b1;
          state_nxt   = S_RESP;
        end
      end
      S_WB: begin
        rspv_d[win] = 1'b1;
        rsp_crc_d   = crc_q;
        state_nxt   = S_RESP;
      end
      S_RESP: begin
        rr_ptr_nxt = (win == IDX_W'(NREQ - 1)) ? '0 : win + 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_d = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      win         <= '0;
      addr_q      <= '0;
      wb_q        <= 1'b0;
      crc_q       <= 1'b0;
      grant_q     <= '0;
      rspv_q      <= '0;
      rsp_crc_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      start_q     <= 1'b0;
      tx_q        <= '0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      win         <= win_nxt;
      addr_q      <= addr_nxt;
      wb_q        <= wb_nxt;
      crc_q       <= crc_nxt;
      grant_q     <= grant_d;
      rspv_q      <= rspv_d;
      rsp_crc_q   <= rsp_crc_d;
      rsp_err_q   <= rsp_err_d;
      ram_cs_q    <= ram_cs_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      start_q     <= start_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_grant   = grant_q;
  assign bus.rsp_valid   = rspv_q;
  assign bus.rsp_crc_ok  = rsp_crc_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.ram_cs      = ram_cs_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.spi_start   = start_q;
  assign bus.spi_tx_data = tx_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb/tb_spi_xfer_arbiter.sv - scoreboard bench for spi_xfer_arbiter with RAM and SPI engine models
module tb_spi_xfer_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 24;

  typedef struct {
    logic [NREQ-1:0] who;
    logic            crc;
    logic            err;
    bit              timed;
  } rsp_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_xfer_arbiter_if #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  spi_xfer_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYC(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NREQ-1:0] grant_q[$];
  logic [DW-1:0]   tx_q[$];
  rsp_t            rsp_q[$];
  wr_t             wr_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // RAM model: one-cycle read latency, bench preload port.
  logic [DW-1:0] mem [32];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.ram_cs && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_cs && !bus.ram_we) bus.ram_rdata <= mem[bus.ram_addr];
  end

  // SPI engine model: fixed frame length, can be told to hang.
  logic [DW-1:0] spi_rx_val  = 24'h123456;
  logic          spi_crc_val = 1'b1;
  logic          spi_hang    = 1'b0;
  logic          force_busy  = 1'b0;
  logic          mdl_busy    = 1'b0;
  int            mdl_cnt     = 0;
  always @(posedge clk) begin
    bus.spi_done <= 1'b0;
    if (bus.spi_start && !mdl_busy) begin
      mdl_busy <= 1'b1;
      mdl_cnt  <= 5;
    end else if (mdl_busy) begin
      if (mdl_cnt > 0) mdl_cnt <= mdl_cnt - 1;
      else if (!spi_hang) begin
        mdl_busy        <= 1'b0;
        bus.spi_done    <= 1'b1;
        bus.spi_rx_data <= spi_rx_val;
        bus.spi_crc_ok  <= spi_crc_val;
      end
    end
  end
  assign bus.spi_busy = mdl_busy | force_busy;

  // Monitor: compares every DUT output event against the scoreboard queues.
  int last_done = -100, last_grant = -100, last_start = -100, rsp_cnt = 0;
  initial forever begin
    rsp_t r;
    wr_t  w;
    @(negedge clk);
    if (bus.spi_done) last_done = cyc;
    if (bus.req_grant != '0) begin
      last_grant = cyc;
      if (grant_q.size() == 0) chk("unexpected_grant", 64'(bus.req_grant), 64'(0));
      else chk("grant", 64'(bus.req_grant), 64'(grant_q.pop_front()));
    end
    if (bus.spi_start) begin
      last_start = cyc;
      chk("start_latency", 64'(cyc - last_grant), 64'(2));
      if (tx_q.size() == 0) chk("unexpected_start", 64'(1), 64'(0));
      else chk("tx_data", 64'(bus.spi_tx_data), 64'(tx_q.pop_front()));
    end
    if (bus.ram_cs && bus.ram_we) begin
      chk("wb_latency", 64'(cyc - last_done), 64'(1));
      if (wr_q.size() == 0) chk("unexpected_write", 64'({bus.ram_addr, bus.ram_wdata}), 64'(0));
      else begin
        w = wr_q.pop_front();
        chk("wb_addr", 64'(bus.ram_addr), 64'(w.a));
        chk("wb_data", 64'(bus.ram_wdata), 64'(w.d));
      end
    end
    if (bus.rsp_valid != '0) begin
      rsp_cnt++;
      if (rsp_q.size() == 0) chk("unexpected_rsp", 64'(bus.rsp_valid), 64'(0));
      else begin
        r = rsp_q.pop_front();
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(r.who));
        chk("rsp_crc_ok", 64'(bus.rsp_crc_ok), 64'(r.crc));
        chk("rsp_err", 64'(bus.rsp_err), 64'(r.err));
        if (r.timed) chk("timeout_latency", 64'(cyc - last_start), 64'(17));
        else         chk("rsp_latency", 64'(cyc - last_done), 64'(2));
      end
    end
  end

  int exp_rsp_n = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic expect_xfer(input int i, input logic [DW-1:0] txw, input logic wb,
                             input logic [AW-1:0] a, input logic crc, input logic [DW-1:0] rxw);
    rsp_t r;
    wr_t  w;
    grant_q.push_back(NREQ'(1) << i);
    tx_q.push_back(txw);
    if (wb && crc) begin
      w.a = a; w.d = rxw;
      wr_q.push_back(w);
    end
    r.who = NREQ'(1) << i; r.crc = crc; r.err = 1'b0; r.timed = 1'b0;
    rsp_q.push_back(r);
    exp_rsp_n++;
  endtask

  task automatic wait_grant(input int i);
    int n = 0;
    while (!bus.req_grant[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("grant_wait_expired", 64'(n), 64'(0));
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (rsp_cnt < exp_rsp_n && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("rsp_wait_expired", 64'(rsp_cnt), 64'(exp_rsp_n));
  endtask

  task automatic single(input int i, input logic [AW-1:0] a, input logic wb);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_wb[i]            = wb;
    bus.req_valid[i]         = 1'b1;
    wait_grant(i);
    bus.req_valid[i]         = 1'b0;
    wait_rsp();
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_ctrl"}, 64'({bus.req_grant, bus.rsp_valid, bus.rsp_crc_ok, bus.rsp_err, bus.ram_cs,
                            bus.ram_we, bus.ram_addr, bus.spi_start, bus.busy}), 64'(0));
    chk({nm, "_tx"}, 64'(bus.spi_tx_data), 64'(0));
    chk({nm, "_wdata"}, 64'(bus.ram_wdata), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_wb    = '0;
    tick(3);
    chk_zero_outputs("reset");
    rst = 1'b0;

    // Single request with write-back.
    preload(5'd0, 24'hABCDEF);
    spi_rx_val = 24'h123456; spi_crc_val = 1'b1;
    expect_xfer(1, 24'hABCDEF, 1'b1, 5'd0, 1'b1, 24'h123456);
    single(1, 5'd0, 1'b1);
    tick(1);
    chk("ram0_after_wb", 64'(mem[0]), 64'(24'h123456));

    // CRC failure must leave RAM untouched.
    preload(5'd0, 24'hABCDEF);
    spi_crc_val = 1'b0;
    expect_xfer(1, 24'hABCDEF, 1'b1, 5'd0, 1'b0, 24'h123456);
    single(1, 5'd0, 1'b1);
    tick(1);
    chk("ram0_crc_fail", 64'(mem[0]), 64'(24'hABCDEF));
    spi_crc_val = 1'b1;

    // Fairness from a fresh rr_ptr with all requesters held.
    rst = 1'b1; tick(2); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      preload(AW'(i + 4), 24'h100000 + DW'(i));
      bus.req_addr[i*AW +: AW] = AW'(i + 4);
    end
    bus.req_wb = '0;
    for (int k = 0; k < 8; k++) expect_xfer(k % 4, 24'h100000 + DW'(k % 4), 1'b0, '0, 1'b1, 24'h123456);
    bus.req_valid = '1;
    for (int k = 0; k < 8; k++) wait_grant(k % 4);
    bus.req_valid = '0;
    wait_rsp();

    // Requester 2 withdraws as requester 3 arrives while the engine is busy.
    force_busy = 1'b1;
    bus.req_addr[2*AW +: AW] = 5'd6;
    bus.req_valid[2] = 1'b1;
    tick(4);
    spi_rx_val = 24'h0A0B0C;
    expect_xfer(3, 24'h100003, 1'b1, 5'd7, 1'b1, 24'h0A0B0C);
    bus.req_addr[3*AW +: AW] = 5'd7;
    bus.req_wb[3] = 1'b1;
    bus.req_valid = 4'b1000;
    force_busy = 1'b0;
    wait_grant(3);
    bus.req_valid = '0;
    wait_rsp();
    tick(1);
    chk("ram7_after_wb", 64'(mem[7]), 64'(24'h0A0B0C));

    // Reset taken mid-XFER: no response, no grant until the engine frees up.
    preload(5'd1, 24'h55AA55);
    preload(5'd2, 24'h3C3C3C);
    spi_hang = 1'b1;
    grant_q.push_back(4'b0001);
    tx_q.push_back(24'h55AA55);
    bus.req_addr[0 +: AW] = 5'd1;
    bus.req_wb[0] = 1'b1;
    bus.req_valid[0] = 1'b1;
    wait_grant(0);
    bus.req_valid[0] = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk_zero_outputs("rst_in_xfer");
    rst = 1'b0;
    bus.req_addr[AW +: AW] = 5'd2;
    bus.req_wb[1] = 1'b0;
    bus.req_valid[1] = 1'b1;
    tick(5);
    chk("held_off_busy", 64'(bus.busy), 64'(0));
    expect_xfer(1, 24'h3C3C3C, 1'b0, 5'd2, 1'b1, 24'h0A0B0C);
    spi_hang = 1'b0;
    wait_grant(1);
    bus.req_valid[1] = 1'b0;
    wait_rsp();
    chk("ram1_after_abort", 64'(mem[1]), 64'(24'h55AA55));

`ifdef SPI_ARB_TIMEOUT_EN
    begin
      rsp_t r;
      preload(5'd3, 24'h777777);
      spi_hang = 1'b1;
      grant_q.push_back(4'b0001);
      tx_q.push_back(24'h777777);
      r.who = 4'b0001; r.crc = 1'b0; r.err = 1'b1; r.timed = 1'b1;
      rsp_q.push_back(r);
      exp_rsp_n++;
      single(0, 5'd3, 1'b1);
      spi_hang = 1'b0;
      tick(12);
      chk("ram3_after_timeout", 64'(mem[3]), 64'(24'h777777));
    end
`endif

    tick(5);
    chk("grant_q_drained", 64'(grant_q.size()), 64'(0));
    chk("rsp_q_drained", 64'(rsp_q.size() + wr_q.size() + tx_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/spi_xfer_arbiter.md
# spi_xfer_arbiter

Round-robin scheduler that shares one SPI master and its 24-bit word RAM among NREQ requesters. For each granted request it reads the word at the requested RAM address and launches one 32-bit SPI frame (24 data bits followed by CRC-8 SAE-J1850). On completion it optionally writes the received word back to the same address and returns a CRC status to the requester. It sits between client logic and the SPI engine/RAM pair, and is the only block that drives their control inputs.

## Interface
- NREQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 5, RAM address width
- DATA_WIDTH, 24, payload width
- TIMEOUT_CYC, 1024, watchdog limit in clk cycles (used only with SPI_ARB_TIMEOUT_EN)

- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_addr  in  NREQ*ADDR_WIDTH  requester i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wb  in  NREQ  write received word back to RAM
- req_grant  out  NREQ  one-hot, one-cycle pulse: request accepted
- rsp_valid  out  NREQ  one-hot, one-cycle pulse: transaction finished
- rsp_crc_ok  out  1  CRC status, valid with rsp_valid
- rsp_err  out  1  timeout abort, valid with rsp_valid
- ram_cs, ram_we  out  1 each  RAM controls
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  DATA_WIDTH  write data
- ram_rdata  in  DATA_WIDTH  read data, valid one cycle after the cs & !we cycle
- spi_start  out  1  one-cycle frame launch
- spi_tx_data  out  DATA_WIDTH  word to transmit, held stable from LAUNCH to done
- spi_busy  in  1  engine active
- spi_done  in  1  one-cycle end-of-frame pulse
- spi_rx_data  in  DATA_WIDTH  received word, valid with spi_done
- spi_crc_ok  in  1  received CRC matched, valid with spi_done
- busy  out  1  high in every state except IDLE

## Operation
- **IDLE:** if any req_valid and !spi_busy, select the winner: the first set bit at or after rr_ptr, searching with wrap-around. Latch its index, address and wb bit, then go to RD.
- **RD:** req_grant[winner]=1, ram_cs=1, ram_we=0, ram_addr=latched address. Go to RDW.
- **RDW:** capture ram_rdata into spi_tx_data. Go to LAUNCH.
- **LAUNCH:** spi_start=1. Go to XFER. spi_done is ignored in this cycle.
- **XFER:** wait for spi_done. When it arrives, capture spi_rx_data and spi_crc_ok, then go to WB.
- **WB:** if latched wb=1 and crc_ok=1, assert ram_cs=1, ram_we=1, ram_addr=latched address, ram_wdata=rx word. Otherwise the RAM controls stay 0. Go to RESP.
- **RESP:** rsp_valid[winner]=1 with rsp_crc_ok and rsp_err. Set rr_ptr=(winner+1) mod NREQ. Go to IDLE.
- A requester holds req_valid and req_addr until it sees req_grant. Dropping req_valid before grant withdraws the request. req_valid is ignored outside IDLE.
- A CRC failure never writes the RAM.

## Timing
- Reset values: all outputs 0, state IDLE, rr_ptr 0, spi_tx_data 0.
- Reset is taken in any state, including XFER. No response is issued for the aborted transaction.
- After reset, IDLE holds off new grants until spi_busy=0.
- Request sampled in IDLE at cycle 0: req_grant and RAM read at cycle 1, tx word captured at cycle 2, spi_start at cycle 3.
- spi_done at cycle D: write-back at D+1, rsp_valid at D+2, next grant no earlier than D+4.
- All outputs are registered. Only one grant is issued per transaction.
- NREQ not a power of two: rr_ptr wraps from NREQ-1 to 0.

## Configuration
- **SPI_ARB_TIMEOUT_EN defined:**
  - A cycle counter runs in XFER. Reaching TIMEOUT_CYC without spi_done goes to RESP with rsp_err=1 and rsp_crc_ok=0, and no write-back.
  - A late spi_done arriving after the abort is ignored.
- **Not defined:** no counter; rsp_err is tied to 0; XFER waits indefinitely.

## Test plan
- Single request: requester 1, addr 0, RAM[0]=0xABCDEF, wb=1. SPI model returns 0x123456 with crc_ok=1. Expect spi_tx_data=0xABCDEF, RAM[0]=0x123456, rsp_valid=4'b0010, rsp_crc_ok=1.
- CRC fail: same stimulus with crc_ok=0. Expect RAM[0] unchanged at 0xABCDEF, rsp_crc_ok=0, no ram_we pulse.
- Fairness: all 4 requesters held valid for 8 transactions. Expect grant order 0,1,2,3,0,1,2,3.
- Withdraw and reset: requester 2 drops req_valid in the same cycle requester 3 raises it, giving grant 3. rst asserted during XFER gives all outputs 0 the next cycle, no rsp_valid, and no grant while spi_busy=1.
- Timeout (with SPI_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): spi_done never arrives. Expect rsp_valid 16 cycles after XFER entry, rsp_err=1, RAM untouched. A spi_done injected afterwards has no effect.
